alu_arbiter: RTL and testbench

- Shares the single combinational ALU between NUM_REQ requesters, e.g. the issue port, a debug port and a test port.
- Round-robin arbitration; only one operation is in flight at a time.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- The block holds operands stable into the ALU, registers the result, and returns it to the granted requester. It sits between the requesters and the ALU math block.

---
 rtl/simple_processor_pkg.sv | 24 ++
 rtl/alu_arbiter_if.sv | 36 +++
 rtl/rr_pick.sv | 33 +++
 rtl/alu_arbiter.sv | 129 ++++++++++++
 tb/tb_alu_arbiter.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/simple_processor_pkg.sv
// Shared types for the simple processor: data width, ALU function
// codes and the ALU arbiter state encoding.
package simple_processor_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [3:0] {
    ADDI    = 4'd0,
    ADD     = 4'd1,
    SUB     = 4'd2,
    INVALID = 4'd15
  } alu_func_e;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_e;

  function automatic logic func_supported(logic [3:0] f);
    return (f == ADDI) || (f == ADD) || (f == SUB);
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side bundle of the ALU arbiter: per-requester request and
// response valid/ready channels plus packed operands, shared result.
interface alu_arbiter_if
  import simple_processor_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int IMM_WIDTH  = 6,
  parameter int FUNC_WIDTH = 4
) ();

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_rs1;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_rs2;
  logic [NUM_REQ*IMM_WIDTH-1:0]  req_imm;
  logic [NUM_REQ*FUNC_WIDTH-1:0] req_func;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [NUM_REQ-1:0]            rsp_ready;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic                          rsp_err;

  modport master (
    output req_valid, req_rs1, req_rs2,
    output req_imm, req_func, rsp_ready,
    input  req_ready, rsp_valid,
    input  rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_rs1, req_rs2,
    input  req_imm, req_func, rsp_ready,
    output req_ready, rsp_valid,
    output rsp_data, rsp_err
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of i_req scanning
// upward from i_last+1 (mod NUM_REQ); o_gnt one-hot, o_idx its index.
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int IW      = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_last,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IW-1:0]      o_idx,
  output logic               o_any
);

  logic [IW-1:0] w_k;
  logic          w_found;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_k     = '0;
    w_found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_k = IW'((int'(i_last) + i) % NUM_REQ);
      if (!w_found && i_req[w_k]) begin
        w_found    = 1'b1;
        o_gnt[w_k] = 1'b1;
        o_idx      = w_k;
      end
    end
    o_any = w_found;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between NUM_REQ
// requesters. Ports: clk_i, arst_ni, requester bus (slave), alu_*_o
// operands out, alu_result_i in, busy_o.
module alu_arbiter
  import simple_processor_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int IMM_WIDTH  = 6,
  parameter int FUNC_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  alu_arbiter_if.slave          bus,
  output logic [DATA_WIDTH-1:0] alu_rs1_o,
  output logic [DATA_WIDTH-1:0] alu_rs2_o,
  output logic [IMM_WIDTH-1:0]  alu_imm_o,
  output logic [FUNC_WIDTH-1:0] alu_func_o,
  input  logic [DATA_WIDTH-1:0] alu_result_i,
  output logic                  busy_o
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e r_state, w_state_d;

  logic [IW-1:0]         r_last;
  logic [IW-1:0]         r_idx;
  logic [IW-1:0]         w_idx;
  logic [NUM_REQ-1:0]    w_gnt;
  logic [NUM_REQ-1:0]    w_sel;
  logic                  w_any;
  logic                  w_exec;
  logic                  w_ok;
  logic [DATA_WIDTH-1:0] r_rs1, r_rs2, r_data;
  logic [DATA_WIDTH-1:0] w_rs1, w_rs2;
  logic [IMM_WIDTH-1:0]  r_imm, w_imm;
  logic [FUNC_WIDTH-1:0] r_func, w_func;
  logic                  r_err;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .i_req  (bus.req_valid),
    .i_last (r_last),
    .o_gnt  (w_gnt),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  always_comb begin
    w_rs1  = '0;
    w_rs2  = '0;
    w_imm  = '0;
    w_func = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_gnt[k]) begin
        w_rs1  = bus.req_rs1[k*DATA_WIDTH +: DATA_WIDTH];
        w_rs2  = bus.req_rs2[k*DATA_WIDTH +: DATA_WIDTH];
        w_imm  = bus.req_imm[k*IMM_WIDTH +: IMM_WIDTH];
        w_func = bus.req_func[k*FUNC_WIDTH +: FUNC_WIDTH];
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      IDLE:    if (w_any) w_state_d = EXEC;
      EXEC:    w_state_d = RESP;
      RESP:    if (bus.rsp_ready[r_idx]) w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  assign w_exec = (r_state == EXEC);
  assign w_sel  = NUM_REQ'(1) << r_idx;
  assign w_ok   = func_supported(4'(r_func));

  // Gated by reset so no grant is offered while the block is held.
  assign bus.req_ready =
    (r_state == IDLE && arst_ni) ? w_gnt : '0;
  assign bus.rsp_valid =
    (r_state == RESP) ? w_sel : '0;
  assign bus.rsp_data  = r_data;
  assign bus.rsp_err   = r_err;

  assign alu_rs1_o  = w_exec ? r_rs1  : '0;
  assign alu_rs2_o  = w_exec ? r_rs2  : '0;
  assign alu_imm_o  = w_exec ? r_imm  : '0;
  assign alu_func_o = w_exec ? r_func : '0;
  assign busy_o     = (r_state != IDLE);

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_state <= IDLE;
      r_last  <= IW'(NUM_REQ - 1);
      r_idx   <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_imm   <= '0;
      r_func  <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_idx  <= w_idx;
            r_rs1  <= w_rs1;
            r_rs2  <= w_rs2;
            r_imm  <= w_imm;
            r_func <= w_func;
          end
        end
        EXEC: begin
          r_data <= w_ok ? alu_result_i : '0;
          r_err  <= !w_ok;
        end
        RESP: begin
          if (bus.rsp_ready[r_idx]) r_last <= r_idx;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus a randomized soak
// against a cycle-level round-robin reference model.
module tb_alu_arbiter;
  import simple_processor_pkg::*;

  localparam int N         = 3;
  localparam int IMMW      = 6;
  localparam int FW        = 4;
  localparam int MAX_STALL = 5;
  localparam int BOUND     = N * (3 + MAX_STALL);

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic [31:0] alu_rs1, alu_rs2, alu_res;
  logic [5:0]  alu_imm;
  logic [3:0]  alu_func;
  logic        busy;

  always #5 clk = ~clk;

  alu_arbiter_if #(
    .NUM_REQ(N), .IMM_WIDTH(IMMW), .FUNC_WIDTH(FW)
  ) bus ();

  alu_arbiter #(
    .NUM_REQ(N), .IMM_WIDTH(IMMW), .FUNC_WIDTH(FW)
  ) dut (
    .clk_i        (clk),
    .arst_ni      (arst_n),
    .bus          (bus),
    .alu_rs1_o    (alu_rs1),
    .alu_rs2_o    (alu_rs2),
    .alu_imm_o    (alu_imm),
    .alu_func_o   (alu_func),
    .alu_result_i (alu_res),
    .busy_o       (busy)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] v_rs1 [N];
  logic [31:0] v_rs2 [N];
  logic [5:0]  v_imm [N];
  logic [3:0]  v_func[N];

  // ALU math; garbage for unsupported codes so zeroing is visible.
  function automatic logic [31:0] alu_ref(
    logic [31:0] a, logic [31:0] b, logic [5:0] imm, logic [3:0] f);
    if (f == ADDI) return a + {{26{imm[5]}}, imm};
    if (f == ADD)  return a + b;
    if (f == SUB)  return a - b;
    return 32'hDEAD_BEEF;
  endfunction

  assign alu_res = alu_ref(alu_rs1, alu_rs2, alu_imm, alu_func);

  function automatic int pick(logic [N-1:0] v, int lst);
    int k;
    for (int i = 1; i <= N; i++) begin
      k = (lst + i) % N;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [3:0] rnd_func();
    if ($urandom_range(0, 15) == 0) return INVALID;
    case ($urandom_range(0, 2))
      0:       return ADDI;
      1:       return ADD;
      default: return SUB;
    endcase
  endfunction

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      bus.req_rs1[k*32 +: 32]  = v_rs1[k];
      bus.req_rs2[k*32 +: 32]  = v_rs2[k];
      bus.req_imm[k*6 +: 6]    = v_imm[k];
      bus.req_func[k*4 +: 4]   = v_func[k];
    end
  endtask

  task automatic reset_dut();
    arst_n = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    @(negedge clk);
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    bus.req_valid = 3'b111;
    #1;
    checks++;
    if (bus.req_ready !== 3'b000) begin
      failures++;
      $display("FAIL rst_ready: got %b want 000", bus.req_ready);
    end
    checks++;
    if ({busy, bus.rsp_valid, bus.rsp_err, bus.rsp_data} !== '0) begin
      failures++;
      $display("FAIL rst_outs: busy=%b vld=%b err=%b data=%h want 0",
               busy, bus.rsp_valid, bus.rsp_err, bus.rsp_data);
    end
    checks++;
    if ({alu_rs1, alu_rs2, alu_imm, alu_func} !== '0) begin
      failures++;
      $display("FAIL rst_alu: got %h/%h/%h/%h want 0",
               alu_rs1, alu_rs2, alu_imm, alu_func);
    end
    @(negedge clk);
    arst_n = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 3'b001) begin
      failures++;
      $display("FAIL rst_first_grant: got %b want 001", bus.req_ready);
    end
    bus.req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_single_add();
    v_rs1[0] = 32'd5; v_rs2[0] = 32'd7; v_func[0] = ADD; v_imm[0] = '0;
    drive();
    bus.rsp_ready = 3'b111;
    bus.req_valid = 3'b001;
    #1;
    checks++;
    if (bus.req_ready !== 3'b001 || busy !== 1'b0) begin
      failures++;
      $display("FAIL add_ready: got %b busy=%b want 001 busy=0",
               bus.req_ready, busy);
    end
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    checks++;
    if (alu_func !== 4'(ADD) || alu_rs1 !== 32'd5 || alu_rs2 !== 32'd7) begin
      failures++;
      $display("FAIL add_exec: got f=%h a=%0d b=%0d want f=1 a=5 b=7",
               alu_func, alu_rs1, alu_rs2);
    end
    @(negedge clk); #1;
    checks++;
    if (bus.rsp_valid !== 3'b001 || bus.rsp_data !== 32'd12 ||
        bus.rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL add_resp: got v=%b d=%0d e=%b want 001 12 0",
               bus.rsp_valid, bus.rsp_data, bus.rsp_err);
    end
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b0 || bus.rsp_valid !== 3'b000) begin
      failures++;
      $display("FAIL add_idle: got busy=%b v=%b want 0 000",
               busy, bus.rsp_valid);
    end
  endtask

  task automatic test_round_robin();
    int e;
    reset_dut();
    for (int k = 0; k < N; k++) begin
      v_rs1[k] = 32'(k * 10); v_rs2[k] = '0;
      v_imm[k] = 6'd1; v_func[k] = ADDI;
    end
    drive();
    bus.rsp_ready = 3'b111;
    bus.req_valid = 3'b111;
    for (int i = 0; i < 4; i++) begin
      e = i % N;
      if (i > 0) @(negedge clk);
      #1;
      checks++;
      if (bus.req_ready !== 3'(1 << e)) begin
        failures++;
        $display("FAIL rr_grant%0d: got %b want %b",
                 i, bus.req_ready, 3'(1 << e));
      end
      @(negedge clk); #1;
      checks++;
      if (alu_rs1 !== 32'(e * 10) || alu_imm !== 6'd1) begin
        failures++;
        $display("FAIL rr_exec%0d: got a=%0d i=%0d want %0d 1",
                 i, alu_rs1, alu_imm, e * 10);
      end
      @(negedge clk); #1;
      checks++;
      if (bus.rsp_valid !== 3'(1 << e) ||
          bus.rsp_data !== 32'(e * 10 + 1)) begin
        failures++;
        $display("FAIL rr_resp%0d: got v=%b d=%0d want %b %0d",
                 i, bus.rsp_valid, bus.rsp_data, 3'(1 << e), e * 10 + 1);
      end
    end
    bus.req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    v_rs1[1] = 32'd3; v_rs2[1] = 32'd5; v_func[1] = SUB;
    drive();
    bus.rsp_ready = 3'b101;
    bus.req_valid = 3'b010;
    #1;
    checks++;
    if (bus.req_ready !== 3'b010) begin
      failures++;
      $display("FAIL bp_grant: got %b want 010", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = 3'b101;
    #1;
    checks++;
    if (alu_func !== 4'(SUB) || bus.req_ready !== 3'b000) begin
      failures++;
      $display("FAIL bp_exec: got f=%h rdy=%b want 2 000",
               alu_func, bus.req_ready);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      checks++;
      if (bus.rsp_valid !== 3'b010 || bus.rsp_data !== 32'hFFFF_FFFE ||
          bus.req_ready !== 3'b000) begin
        failures++;
        $display("FAIL bp_hold%0d: got v=%b d=%h rdy=%b want 010 fffffffe 000",
                 c, bus.rsp_valid, bus.rsp_data, bus.req_ready);
      end
    end
    bus.rsp_ready = 3'b111;
    @(negedge clk); #1;
    checks++;
    if (bus.req_ready !== 3'b100 || bus.rsp_valid !== 3'b000) begin
      failures++;
      $display("FAIL bp_release: got rdy=%b v=%b want 100 000",
               bus.req_ready, bus.rsp_valid);
    end
    bus.req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_invalid();
    v_rs1[2] = $urandom; v_rs2[2] = $urandom; v_func[2] = INVALID;
    drive();
    bus.req_valid = 3'b100;
    #1;
    checks++;
    if (bus.req_ready !== 3'b100) begin
      failures++;
      $display("FAIL inv_grant: got %b want 100", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk); #1;
    checks++;
    if (bus.rsp_valid !== 3'b100 || bus.rsp_err !== 1'b1 ||
        bus.rsp_data !== 32'd0) begin
      failures++;
      $display("FAIL inv_resp: got v=%b e=%b d=%h want 100 1 0",
               bus.rsp_valid, bus.rsp_err, bus.rsp_data);
    end
    @(negedge clk);
    v_rs1[0] = 32'd1; v_rs2[0] = 32'd2; v_func[0] = ADD;
    drive();
    bus.req_valid = 3'b001;
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk); #1;
    checks++;
    if (bus.rsp_valid !== 3'b001 || bus.rsp_err !== 1'b0 ||
        bus.rsp_data !== 32'd3) begin
      failures++;
      $display("FAIL inv_next: got v=%b e=%b d=%0d want 001 0 3",
               bus.rsp_valid, bus.rsp_err, bus.rsp_data);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    v_rs1[1] = 32'd10; v_rs2[1] = 32'd20; v_func[1] = ADD;
    drive();
    bus.req_valid = 3'b011;
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b1 || alu_rs1 !== 32'd10) begin
      failures++;
      $display("FAIL mid_exec: got busy=%b a=%0d want 1 10", busy, alu_rs1);
    end
    #2 arst_n = 1'b0;
    #1;
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_data,
         alu_rs1, alu_rs2, alu_imm, alu_func, busy} !== '0) begin
      failures++;
      $display("FAIL mid_zero: rdy=%b v=%b e=%b d=%h a=%h f=%h busy=%b want 0",
               bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_data,
               alu_rs1, alu_func, busy);
    end
    @(negedge clk);
    arst_n = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 3'b001) begin
      failures++;
      $display("FAIL mid_regrant: got %b want 001", bus.req_ready);
    end
    bus.req_valid = '0;
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b0 || bus.rsp_valid !== 3'b000) begin
      failures++;
      $display("FAIL mid_norsp: got busy=%b v=%b want 0 000",
               busy, bus.rsp_valid);
    end
  endtask

  task automatic test_soak();
    int          owner, age, last, stall, acc, g;
    int          accepted, completed, worst;
    int          waitc[N];
    logic [31:0] e_data, e_rs1, e_rs2;
    logic [5:0]  e_imm;
    logic [3:0]  e_func;
    logic        e_err;
    logic [N-1:0] e_rdy, e_vld;
    owner = -1; age = 0; last = N - 1; stall = 0;
    accepted = 0; completed = 0; worst = 0;
    e_data = '0; e_err = 1'b0;
    e_rs1 = '0; e_rs2 = '0; e_imm = '0; e_func = '0;
    for (int k = 0; k < N; k++) waitc[k] = 0;
    reset_dut();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      acc = -1;
      if (owner < 0) begin
        g = pick(bus.req_valid, last);
        if (g >= 0) begin
          owner = g; age = 0; stall = 0; acc = g; accepted++;
          e_rs1 = v_rs1[g]; e_rs2 = v_rs2[g];
          e_imm = v_imm[g]; e_func = v_func[g];
          e_err = !(e_func == ADDI || e_func == ADD || e_func == SUB);
          e_data = e_err ? 32'd0 : alu_ref(e_rs1, e_rs2, e_imm, e_func);
          checks++;
          if (waitc[g] > BOUND) begin
            failures++;
            $display("FAIL soak_wait: req%0d waited %0d want <= %0d",
                     g, waitc[g], BOUND);
          end
          if (waitc[g] > worst) worst = waitc[g];
        end
      end else if (age == 0) begin
        age = 1;
      end else if (bus.rsp_ready[owner]) begin
        last = owner; owner = -1; completed++;
      end else begin
        stall++;
      end
      for (int k = 0; k < N; k++) begin
        if (k == acc) begin
          bus.req_valid[k] = 1'b0;
          waitc[k] = 0;
        end else if (bus.req_valid[k]) begin
          waitc[k]++;
        end
        if (!bus.req_valid[k] && k != acc && $urandom_range(0, 3) == 0) begin
          bus.req_valid[k] = 1'b1;
          waitc[k] = 0;
        end
        if ($urandom_range(0, 3) == 0 || k == acc) begin
          v_rs1[k] = $urandom; v_rs2[k] = $urandom;
          v_imm[k] = 6'($urandom); v_func[k] = rnd_func();
        end
      end
      bus.rsp_ready = 3'($urandom);
      if (owner >= 0 && age == 1 && stall >= MAX_STALL)
        bus.rsp_ready[owner] = 1'b1;
      drive();
      #1;
      e_rdy = '0;
      e_vld = '0;
      if (owner < 0) begin
        g = pick(bus.req_valid, last);
        if (g >= 0) e_rdy[g] = 1'b1;
      end else if (age == 1) begin
        e_vld[owner] = 1'b1;
      end
      checks++;
      if (bus.req_ready !== e_rdy || busy !== (owner >= 0)) begin
        failures++;
        $display("FAIL soak_ready c%0d: got %b busy=%b want %b busy=%b",
                 cyc, bus.req_ready, busy, e_rdy, owner >= 0);
      end
      checks++;
      if (bus.rsp_valid !== e_vld) begin
        failures++;
        $display("FAIL soak_rspvld c%0d: got %b want %b",
                 cyc, bus.rsp_valid, e_vld);
      end
      if (owner >= 0 && age == 0) begin
        checks++;
        if ({alu_rs1, alu_rs2, alu_imm, alu_func} !==
            {e_rs1, e_rs2, e_imm, e_func}) begin
          failures++;
          $display("FAIL soak_alu c%0d: got %h/%h/%h/%h want %h/%h/%h/%h",
                   cyc, alu_rs1, alu_rs2, alu_imm, alu_func,
                   e_rs1, e_rs2, e_imm, e_func);
        end
      end else begin
        checks++;
        if ({alu_rs1, alu_rs2, alu_imm, alu_func} !== '0) begin
          failures++;
          $display("FAIL soak_alu_zero c%0d: got %h/%h/%h/%h want 0",
                   cyc, alu_rs1, alu_rs2, alu_imm, alu_func);
        end
      end
      if (owner >= 0 && age == 1) begin
        checks++;
        if (bus.rsp_data !== e_data || bus.rsp_err !== e_err) begin
          failures++;
          $display("FAIL soak_data c%0d: got %h e=%b want %h e=%b",
                   cyc, bus.rsp_data, bus.rsp_err, e_data, e_err);
        end
      end
    end
    bus.req_valid = '0;
    for (int k = 0; k < N; k++) if (waitc[k] > worst) worst = waitc[k];
    checks++;
    if (worst > BOUND || accepted < 100) begin
      failures++;
      $display("FAIL soak_progress: worst wait %0d accepted %0d want <=%0d >=100",
               worst, accepted, BOUND);
    end
    checks++;
    if (accepted - completed !== ((owner >= 0) ? 1 : 0)) begin
      failures++;
      $display("FAIL soak_count: accepted %0d completed %0d inflight %0d",
               accepted, completed, owner >= 0);
    end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    for (int k = 0; k < N; k++) begin
      v_rs1[k] = '0; v_rs2[k] = '0; v_imm[k] = '0; v_func[k] = '0;
    end
    drive();
    @(negedge clk);
    test_reset();
    test_single_add();
    test_round_robin();
    test_backpressure();
    test_invalid();
    test_reset_mid();
    test_soak();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
